// File: rtl/line_buffer.sv
// Multi-row pixel line buffer: serial byte writes, parallel n-byte window
// per row at a shared column, combinational output.
module line_buffer #(
  parameter int M          = 3,
  parameter int W          = 512,
  parameter int n          = 4,
  parameter int PNTR_WIDTH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_data,
  input  logic                 i_data_valid,
  input  logic                 i_rd_data,
  output logic [M*n*8-1:0]     o_data
);

  localparam int DEPTH  = M * W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RD_W   = $clog2(W);

  logic [7:0]            line [DEPTH];
  logic [PNTR_WIDTH-1:0] wr_pntr;
  logic [RD_W-1:0]       rd_pntr;

  // Whole array clears on reset so the window reads zero until refilled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_pntr <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        line[k] <= '0;
      end
    end else if (i_data_valid) begin
      line[wr_pntr[ADDR_W-1:0]] <= i_data;
      if (wr_pntr == PNTR_WIDTH'(DEPTH - 1)) begin
        wr_pntr <= '0;
      end else begin
        wr_pntr <= wr_pntr + 1'b1;
      end
    end
  end

  // Read pointer stops at the last full window start so taps never cross rows.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_pntr <= '0;
    end else if (i_rd_data) begin
      if (rd_pntr == RD_W'(W - n)) begin
        rd_pntr <= '0;
      end else begin
        rd_pntr <= rd_pntr + 1'b1;
      end
    end
  end

  // Row 0 in the most-significant bytes; tap 0 is the MS byte of each row.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    idx    = '0;
    o_data = '0;
    for (int unsigned i = 0; i < M; i++) begin
      for (int unsigned j = 0; j < n; j++) begin
        idx = ADDR_W'(i * W + j + 32'(rd_pntr));
        o_data[(M-1-i)*n*8 + (n-1-j)*8 +: 8] = line[idx];
      end
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: vector table plus scoreboard queue,
// with hand sequences for wrap, overwrite and asynchronous reset.
module tb_line_buffer;

  localparam int M  = 3;
  localparam int W  = 512;
  localparam int N  = 4;
  localparam int PW = 12;
  localparam int OW = M * N * 8;

  logic          i_clk;
  logic          i_rst;
  logic [7:0]    i_data;
  logic          i_data_valid;
  logic          i_rd_data;
  logic [OW-1:0] o_data;

  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] sb_q[$];

  typedef struct {
    logic          rd;
    logic          wv;
    logic [7:0]    d;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  line_buffer #(.M(M), .W(W), .n(N), .PNTR_WIDTH(PW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Window of the index%256 fill pattern at column k, replicated per row.
  function automatic logic [OW-1:0] win(input int k);
    logic [31:0] r;
    for (int j = 0; j < N; j++) r[(N-1-j)*8 +: 8] = 8'(k + j);
    return {3{r}};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rd, input logic wv, input logic [7:0] d);
    @(negedge i_clk);
    i_rd_data    = rd;
    i_data_valid = wv;
    i_data       = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic sb_step(input string name, input logic rd, input logic wv,
                         input logic [7:0] d, input logic [OW-1:0] exp);
    logic [OW-1:0] e;
    sb_q.push_back(exp);
    step(rd, wv, d);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got %h expected entry", name, o_data);
    end else begin
      e = sb_q.pop_front();
      check(name, o_data, e);
    end
  endtask

  initial begin
    i_rst        = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_rd_data    = 1'b0;

    for (int k = 0; k < 10; k++) begin
      vecs[k].rd  = 1'b1;
      vecs[k].wv  = 1'b0;
      vecs[k].d   = 8'h00;
      vecs[k].exp = win(k + 1);
    end

    #30;
    check("reset_hold", o_data, '0);
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, 8'h00);
    check("reset_idle", o_data, '0);

    for (int i = 0; i < M * W; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    check("window0", o_data, win(0));

    for (int v = 0; v < 10; v++) begin
      sb_step($sformatf("rd_adv_%0d", v + 1), vecs[v].rd, vecs[v].wv, vecs[v].d, vecs[v].exp);
    end

    repeat (497) step(1'b1, 1'b0, 8'h00);
    sb_step("rd_last_window", 1'b1, 1'b0, 8'h00, win(508));
    sb_step("rd_wrap", 1'b1, 1'b0, 8'h00, win(0));

    sb_step("wr_wrap_aa", 1'b0, 1'b1, 8'hAA, {8'hAA, win(0)[OW-9:0]});
    sb_step("wr_rd_same_edge", 1'b1, 1'b1, 8'hBB,
            {8'hBB, 8'h02, 8'h03, 8'h04, win(1)[63:0]});
    sb_step("idle_hold", 1'b0, 1'b0, 8'hCC,
            {8'hBB, 8'h02, 8'h03, 8'h04, win(1)[63:0]});

    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h40 + i));
    @(negedge i_clk);
    i_rd_data    = 1'b0;
    i_data_valid = 1'b1;
    i_data       = 8'h77;
    #2;
    i_rst = 1'b0;
    #1;
    check("async_reset_no_edge", o_data, '0);
    @(posedge i_clk);
    #1;
    check("reset_blocks_write", o_data, '0);
    @(negedge i_clk);
    i_data_valid = 1'b0;
    i_rst        = 1'b1;
    sb_step("post_reset_wr0", 1'b0, 1'b1, 8'h5A, {8'h5A, 88'h0});
    sb_step("post_reset_wr1", 1'b0, 1'b1, 8'h5B, {8'h5A, 8'h5B, 80'h0});

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
